imem_line_server: RTL

Memory-side responder for the instruction-cache line-fill interface. It accepts one line-refill request at a time from the I-cache and reads the requested 16-byte line from an internal word-organised instruction store. It returns the line as LINE_WORDS beats over a valid/ready stream, critical word first with wrap-around inside the line. A preload port writes the store from the testbench or boot loader.

---
 rtl/imem_line_server.sv | 111 +++++++++++
 1 files changed

// File: rtl/imem_line_server.sv
// Instruction-store line server: returns one cache line per refill request,
// critical word first, wrapping inside the line, over a valid/ready stream.
module imem_line_server #(
  parameter int          IMEM_WORDS      = 1024,
  parameter int          WORD_ADDR_WIDTH = 10,
  parameter int          LINE_WORDS      = 4,
  parameter logic [31:0] ERR_DATA        = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [31:0]                resp_data,
  output logic [$clog2(LINE_WORDS)-1:0] resp_word,
  output logic                       resp_last,
  output logic                       resp_err,
  input  logic                       prog_we,
  input  logic [WORD_ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]                prog_data
);
  localparam int          OW    = $clog2(LINE_WORDS);
  localparam int          BW    = WORD_ADDR_WIDTH - OW;
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} state_t;

  typedef struct packed {
    logic [BW-1:0] base;
    logic [OW-1:0] word;
    logic          err;
  } line_t;

  state_t        r_state, w_next;
  line_t         r_line;
  logic          r_req_ready;
  logic [OW-1:0] r_cnt;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [IMEM_WORDS];

  logic          w_accept, w_beat, w_last, w_rd_en;
  logic [OW-1:0] w_rd_word, w_word_nxt;

  assign w_accept   = req_valid && r_req_ready;
  assign w_beat     = (r_state == S_RESP) && resp_ready;
  assign w_last     = (r_cnt == OW'(LINE_WORDS - 1));
  assign w_word_nxt = r_line.word + OW'(1);

  always_comb begin
    w_next    = r_state;
    w_rd_en   = 1'b0;
    w_rd_word = r_line.word;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_READ;
      S_READ: begin
        w_next  = S_RESP;
        w_rd_en = !r_line.err;
      end
      S_RESP: begin
        if (w_beat) begin
          if (w_last) begin
            w_next = S_IDLE;
          end else begin
            // next word is fetched on the same edge the current beat retires
            w_rd_en   = !r_line.err;
            w_rd_word = w_word_nxt;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_line      <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == S_IDLE);
      if (w_accept) begin
        r_line.base <= req_addr[WORD_ADDR_WIDTH+1:OW+2];
        r_line.word <= req_addr[OW+1:2];
        r_line.err  <= (req_addr >= LIMIT);
        r_cnt       <= '0;
      end
      if (w_beat && !w_last) begin
        r_line.word <= w_word_nxt;
        r_cnt       <= r_cnt + OW'(1);
      end
      if (w_rd_en) r_rdata <= r_mem[{r_line.base, w_rd_word}];
    end
  end

  // store is deliberately unreset; same-edge write/read returns the old word
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = (r_state == S_RESP);
  assign resp_word  = r_line.word;
  assign resp_last  = w_last;
  assign resp_err   = r_line.err;
  assign resp_data  = r_line.err ? ERR_DATA : r_rdata;
endmodule
